arm_dmem_ctrl: RTL



---
 rtl/arm_mem_pkg.sv | 35 +++
 rtl/arm_dmem_array.sv | 35 +++
 rtl/arm_dmem_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the ARM data-memory block.
//   dmem_state_t : controller FSM states (IDLE, WAIT, RESP)
//   MAX_WAIT     : largest supported number of wait states
//   CNT_W        : width of the wait-state counter
//   be_merge()   : byte-lane merge of a store into an existing word; it works
//                  on words up to MAX_DATA_W bits, and callers cast to and from
//                  their own width.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int MAX_WAIT   = 7;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Lanes with be[i] = 1 take new_word, and the other lanes keep old_word.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/arm_dmem_array.sv
// Word-organised storage for the data memory.
//   clk   : clock
//   we    : write the byte lanes selected by be into word idx
//   idx   : word index
//   be    : byte-lane enables for the write
//   wdata : store data
//   rdata : registered read of word idx. On the same edge as a write to idx,
//           it returns the contents from before that write.
module arm_dmem_array
  import arm_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // NOTE: storage has no reset, so it maps onto plain RAM and keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= DATA_W'(be_merge(MAX_DATA_W'(mem_q[idx]), MAX_DATA_W'(wdata),
                                     MAX_BE_W'(be)));
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/arm_dmem_ctrl.sv
// Data-memory controller for the ARM core. It has a valid/ready request
// handshake, WAIT_STATES extra cycles of latency, byte-lane stores, and
// reporting of range and alignment errors.
//   clk, reset          : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake; accepted when both are high
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte-lane enables
//   rsp_valid           : one-cycle response strobe, WAIT_STATES+1 after accept
//   rsp_rdata, rsp_err  : load data (0 on error or store) and error flag,
//                         held until the next response
//   busy                : a request is in flight
module arm_dmem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept, in_idle, enter_resp, arr_we, cur_err, cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, arr_rdata;
  logic [BE_W-1:0]   cur_be;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the array access happens on the accept edge itself,
  // so while idle the array is fed straight from the request inputs.
  assign in_idle   = (state_q == IDLE);
  assign cur_write = in_idle ? req_write : wr_q;
  assign cur_addr  = in_idle ? req_addr  : addr_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_be    = in_idle ? req_be    : be_q;
  assign cur_err   = addr_err(cur_addr);

  // NOTE: every signal is given a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A store commits only on the edge that enters RESP. If reset is active on
  // that edge, the store is dropped.
  assign enter_resp = (state_d == RESP) && !reset;
  assign arr_we     = enter_resp && cur_write && !cur_err;

  arm_dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (cur_addr[IDX_W+1:2]),
    .be    (cur_be),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_q == RESP);
      if (state_q == RESP) begin
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_err || wr_q) ? '0 : arr_rdata;
      end
    end
  end

  // The request capture is datapath only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
